// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM state encodings
// and default datapath sizing.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_ITER = 3'd1,
    DIV_FIX  = 3'd2,
    DIV_DONE = 3'd3,
    DIV_ZERO = 3'd4
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Start/operand/result bundle between the control unit (master) and the
// divider (slave).
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             div_busy;
  logic             div_done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output div_start, dividend, divisor,
    input  div_busy, div_done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  div_start, dividend, divisor,
    output div_busy, div_done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/seq_divider_twos_negate.sv
// Conditional two's-complement negation, used both for operand magnitudes
// and for restoring the signs of the results.
module twos_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_val,
  input  logic             cond,
  output logic [WIDTH-1:0] out_val
);

  assign out_val = cond ? (~in_val + WIDTH'(1)) : in_val;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: quotient truncates toward zero,
// remainder takes the sign of the dividend. One quotient bit per clock.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input logic           clk,
  input logic           reset,
  seq_divider_if.slave  bus
);

  div_state_e       state_r, state_s;
  logic [WIDTH-1:0] r_r, q_r, b_r, quot_r, rem_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sign_q_r, sign_r_r, dbz_r, busy_r, done_r;
  logic [WIDTH-1:0] a_abs_s, b_abs_s, quot_fix_s, rem_fix_s, diff_s;
  logic [WIDTH:0]   shift_s;
  logic             ge_s, last_s, div_zero_s;

  twos_negate #(.WIDTH(WIDTH)) u_abs_a (.in_val(bus.dividend), .cond(bus.dividend[WIDTH-1]), .out_val(a_abs_s));
  twos_negate #(.WIDTH(WIDTH)) u_abs_b (.in_val(bus.divisor),  .cond(bus.divisor[WIDTH-1]),  .out_val(b_abs_s));
  twos_negate #(.WIDTH(WIDTH)) u_fix_q (.in_val(q_r), .cond(sign_q_r), .out_val(quot_fix_s));
  twos_negate #(.WIDTH(WIDTH)) u_fix_r (.in_val(r_r), .cond(sign_r_r), .out_val(rem_fix_s));

  // The shifted partial remainder needs one extra bit; after a successful
  // subtract it always fits back into WIDTH bits.
  always_comb begin
    shift_s    = {r_r, q_r[WIDTH-1]};
    ge_s       = (shift_s >= {1'b0, b_r});
    diff_s     = shift_s[WIDTH-1:0] - b_r;
    last_s     = (cnt_r == CNT_W'(WIDTH - 1));
    div_zero_s = (bus.divisor == {WIDTH{1'b0}});
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      DIV_IDLE: begin
        if (bus.div_start) begin
          state_s = div_zero_s ? DIV_ZERO : DIV_ITER;
        end else begin
          state_s = DIV_IDLE;
        end
      end
      DIV_ITER: begin
        if (last_s) begin
          state_s = DIV_FIX;
        end else begin
          state_s = DIV_ITER;
        end
      end
      DIV_FIX:  state_s = DIV_DONE;
      DIV_DONE: state_s = DIV_IDLE;
      DIV_ZERO: state_s = DIV_IDLE;
      default:  state_s = DIV_IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= DIV_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == DIV_ITER) || (state_s == DIV_FIX) || (state_s == DIV_DONE);
      done_r  <= (state_s == DIV_DONE) || (state_s == DIV_ZERO);
    end
  end

  // Datapath: operand capture, restoring iterations, sign fix-up of results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_r      <= {WIDTH{1'b0}};
      q_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      quot_r   <= {WIDTH{1'b0}};
      rem_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      sign_q_r <= 1'b0;
      sign_r_r <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (bus.div_start && !div_zero_s) begin
            r_r      <= {WIDTH{1'b0}};
            q_r      <= a_abs_s;
            b_r      <= b_abs_s;
            cnt_r    <= {CNT_W{1'b0}};
            sign_q_r <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            sign_r_r <= bus.dividend[WIDTH-1];
            dbz_r    <= 1'b0;
          end else if (bus.div_start) begin
            dbz_r <= 1'b1;
          end else begin
            dbz_r <= dbz_r;
          end
        end
        DIV_ITER: begin
          r_r   <= ge_s ? diff_s : shift_s[WIDTH-1:0];
          q_r   <= {q_r[WIDTH-2:0], ge_s};
          cnt_r <= cnt_r + CNT_W'(1);
        end
        DIV_FIX: begin
          quot_r <= quot_fix_s;
          rem_r  <= rem_fix_s;
        end
        default: begin
          quot_r <= quot_r;
          rem_r  <= rem_r;
        end
      endcase
    end
  end

  assign bus.div_busy    = busy_r;
  assign bus.div_done    = done_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed DIV cases, protocol and reset
// corner cases, plus random operands compared to a 64-bit arithmetic model.
module tb_seq_divider;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q   = 32'd0;
  logic [31:0] exp_r   = 32'd0;
  logic        exp_dbz = 1'b0;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Called at a negedge. Latency counts cycles from the cycle in which
  // div_start is driven (cycle 0) to the first cycle with div_done high.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit pulse);
    int     cycles;
    int     extra_done;
    bit     seen_busy;
    int     exp_lat;
    logic   exp_busy;
    longint sa, sb, sq;
    bus.div_start = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    @(negedge clk);
    bus.div_start = 1'b0;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    cycles    = 1;
    seen_busy = 1'b0;
    while (bus.div_done !== 1'b1 && cycles < 100) begin
      if (bus.div_busy === 1'b1) seen_busy = 1'b1;
      bus.div_start = pulse && (cycles == 5 || cycles == 20);
      @(negedge clk);
      cycles++;
    end
    bus.div_start = 1'b0;
    if (b == 32'd0) begin
      exp_dbz  = 1'b1;
      exp_lat  = 1;
      exp_busy = 1'b0;
    end else begin
      sa       = longint'($signed(a));
      sb       = longint'($signed(b));
      sq       = sa / sb;
      exp_q    = sq[31:0];
      exp_r    = 32'(sa - sq * sb);
      exp_dbz  = 1'b0;
      exp_lat  = 34;
      exp_busy = 1'b1;
      check("busy_during_op", 32'(seen_busy), 32'd1);
    end
    check("latency", cycles, exp_lat);
    check("quotient", bus.quotient, exp_q);
    check("remainder", bus.remainder, exp_r);
    check("div_by_zero", 32'(bus.div_by_zero), 32'(exp_dbz));
    check("busy_at_done", 32'(bus.div_busy), 32'(exp_busy));
    @(negedge clk);
    check("done_one_cycle", 32'(bus.div_done), 32'd0);
    check("busy_after_done", 32'(bus.div_busy), 32'd0);
    if (pulse) begin
      extra_done = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.div_done === 1'b1) extra_done++;
      end
      check("no_extra_done", extra_done, 0);
    end
  endtask

  initial begin
    int          cycles;
    int          dones;
    logic [31:0] a, b;
    bus.div_start = 1'b0;
    bus.dividend  = 32'd0;
    bus.divisor   = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_quotient", bus.quotient, 32'd0);
    check("rst_remainder", bus.remainder, 32'd0);
    check("rst_busy", 32'(bus.div_busy), 32'd0);
    check("rst_done", 32'(bus.div_done), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_div(32'd100, 32'd7, 1'b0);
    run_div(-32'sd7, 32'd2, 1'b0);
    run_div(32'd7, -32'sd2, 1'b0);
    run_div(-32'sd7, -32'sd2, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(32'd0, 32'd5, 1'b0);
    run_div(32'd5, 32'd9, 1'b0);
    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'd123, 32'd0, 1'b0);
    run_div(32'd9, 32'd3, 1'b0);
    run_div(32'd1000, -32'sd13, 1'b1);

    // start held through the DONE cycle must only be taken one cycle later
    bus.div_start = 1'b1;
    bus.dividend  = 32'd77;
    bus.divisor   = 32'd5;
    @(negedge clk);
    bus.div_start = 1'b0;
    cycles = 1;
    while (bus.div_done !== 1'b1 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check("b2b_latency", cycles, 34);
    check("b2b_quotient", bus.quotient, 32'd15);
    check("b2b_remainder", bus.remainder, 32'd2);
    bus.div_start = 1'b1;
    bus.dividend  = -32'sd50;
    bus.divisor   = 32'd7;
    @(negedge clk);
    run_div(-32'sd50, 32'd7, 1'b0);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = $urandom_range(1, 20);
        2:       b = -$urandom_range(1, 1000);
        default: b = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 30));
      endcase
      run_div(a, b, 1'b0);
    end

    // reset asserted mid-iteration aborts and clears outputs at once
    run_div(32'd100, 32'd7, 1'b0);
    bus.div_start = 1'b1;
    bus.dividend  = 32'd500;
    bus.divisor   = 32'd3;
    @(negedge clk);
    bus.div_start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_quotient", bus.quotient, 32'd0);
    check("abort_remainder", bus.remainder, 32'd0);
    check("abort_busy", 32'(bus.div_busy), 32'd0);
    check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_done === 1'b1) dones++;
    end
    check("abort_no_done", dones, 0);
    exp_q   = 32'd0;
    exp_r   = 32'd0;
    exp_dbz = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    run_div(32'd100, 32'd7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
